accel_port: RTL and testbench

Accelerator-side endpoint of the CPU accelerator interface: it answers the CPU's `accel_id` / `can_read` / `can_write` / `read_enable` / `write_enable` handshake for one accelerator ID. It buffers CPU writes into a command FIFO that drains to the accelerator core through a valid/ready stream. It buffers core results into a response FIFO that the CPU reads.

It sits between the CPU accelerator bus and one accelerator core. Several instances with distinct `ID` share the bus; their `accel_can_*` and `accel_read_data` outputs are OR-combined.

---
 rtl/accel_port.sv | 181 ++++++++++++++++++
 tb/tb_accel_port.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_port.sv
// accel_port -- accelerator-side endpoint of the CPU accelerator bus.
//
// Answers the CPU accel_id / can_read / can_write / read_enable /
// write_enable handshake for one accelerator ID. CPU writes are buffered
// in a command FIFO that drains to the core over a valid/ready stream.
// Core results are buffered in a response FIFO that the CPU reads.
// All CPU-facing outputs are zero when the port is not selected, so
// several instances can be OR-combined on one bus.
//
// Handshake semantics (every stream in this file): a word moves on a
// rising clk edge exactly when its valid and ready are both 1 in that
// cycle. Valid never depends on ready. The CPU side uses the same rule,
// with accel_write_enable/accel_read_enable as valid and
// accel_can_write/accel_can_read as ready.
//
// Parameters:
//   ID         accelerator ID this port answers to (0..15)
//   REG_WIDTH  data width of both FIFOs
//   CMD_DEPTH  command FIFO depth (power of two, >= 2)
//   RSP_DEPTH  response FIFO depth (power of two, >= 2)
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   loopback            (only with ACCEL_PORT_LOOPBACK_EN) route commands
//                       straight into the response FIFO
//   accel_id            ID selected by the current CPU instruction
//   accel_can_read      response available (ID matched)
//   accel_can_write     command space available (ID matched)
//   accel_read_enable   CPU pops the response head this cycle
//   accel_read_data     response head, zero when not readable
//   accel_write_enable  CPU pushes accel_write_data this cycle
//   accel_write_data    command word
//   cmd_valid/cmd_data/cmd_ready   command stream toward the core
//   rsp_valid/rsp_data/rsp_ready   response stream from the core
//
// Optional feature macro: ACCEL_PORT_LOOPBACK_EN.
module accel_port #(
    parameter int ID        = 0,
    parameter int REG_WIDTH = 16,
    parameter int CMD_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ACCEL_PORT_LOOPBACK_EN
    input  logic                 loopback,
`endif
    input  logic [3:0]           accel_id,
    output logic                 accel_can_read,
    output logic                 accel_can_write,
    input  logic                 accel_read_enable,
    output logic [REG_WIDTH-1:0] accel_read_data,
    input  logic                 accel_write_enable,
    input  logic [REG_WIDTH-1:0] accel_write_data,
    output logic                 cmd_valid,
    output logic [REG_WIDTH-1:0] cmd_data,
    input  logic                 cmd_ready,
    input  logic                 rsp_valid,
    input  logic [REG_WIDTH-1:0] rsp_data,
    output logic                 rsp_ready
);

    localparam int CMD_AW = $clog2(CMD_DEPTH);
    localparam int CMD_CW = CMD_AW + 1;
    localparam int RSP_AW = $clog2(RSP_DEPTH);
    localparam int RSP_CW = RSP_AW + 1;

    // Command FIFO storage and state
    logic [REG_WIDTH-1:0] cmd_mem [CMD_DEPTH];
    logic [CMD_AW-1:0]    cmd_wptr;
    logic [CMD_AW-1:0]    cmd_rptr;
    logic [CMD_CW-1:0]    cmd_count;
    logic                 cmd_full;
    logic                 cmd_empty;
    logic                 cmd_push;
    logic                 cmd_pop;
    logic [REG_WIDTH-1:0] cmd_head;

    // Response FIFO storage and state
    logic [REG_WIDTH-1:0] rsp_mem [RSP_DEPTH];
    logic [RSP_AW-1:0]    rsp_wptr;
    logic [RSP_AW-1:0]    rsp_rptr;
    logic [RSP_CW-1:0]    rsp_count;
    logic                 rsp_full;
    logic                 rsp_empty;
    logic                 rsp_push;
    logic                 rsp_pop;
    logic [REG_WIDTH-1:0] rsp_wdata;
    logic [REG_WIDTH-1:0] rsp_head;

    logic sel;
    logic lb_active;
    logic lb_move;

`ifdef ACCEL_PORT_LOOPBACK_EN
    assign lb_active = loopback;
`else
    assign lb_active = 1'b0;
`endif

    // Flags come from registered counts only: no same-cycle pass-through.
    assign cmd_full  = (cmd_count == CMD_CW'(CMD_DEPTH));
    assign cmd_empty = (cmd_count == '0);
    assign rsp_full  = (rsp_count == RSP_CW'(RSP_DEPTH));
    assign rsp_empty = (rsp_count == '0);

    assign cmd_head = cmd_mem[cmd_rptr];
    assign rsp_head = rsp_mem[rsp_rptr];

    // CPU side, combinational in accel_id so a stalled instruction sees
    // fresh flags every cycle.
    assign sel             = (accel_id == 4'(ID));
    assign accel_can_write = sel & ~cmd_full;
    assign accel_can_read  = sel & ~rsp_empty;
    assign accel_read_data = accel_can_read ? rsp_head : '0;

    // Loopback moves the command head into the response FIFO and hides
    // both core-facing handshakes.
    assign lb_move   = lb_active & ~cmd_empty & ~rsp_full;
    assign cmd_valid = ~cmd_empty & ~lb_active;
    assign cmd_data  = cmd_empty ? '0 : cmd_head;
    assign rsp_ready = ~rsp_full & ~lb_active;

    assign cmd_push  = accel_write_enable & accel_can_write;
    assign cmd_pop   = (cmd_valid & cmd_ready) | lb_move;
    assign rsp_push  = (rsp_valid & rsp_ready) | lb_move;
    assign rsp_wdata = lb_active ? cmd_head : rsp_data;
    assign rsp_pop   = accel_read_enable & accel_can_read;

    // Storage is not reset: an empty FIFO never exposes its contents.
    always_ff @(posedge clk) begin
        if (cmd_push) begin
            cmd_mem[cmd_wptr] <= accel_write_data;
        end
        if (rsp_push) begin
            rsp_mem[rsp_wptr] <= rsp_wdata;
        end
    end

    // Pointers wrap naturally because depths are powers of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_wptr  <= '0;
            cmd_rptr  <= '0;
            cmd_count <= '0;
        end else begin
            if (cmd_push) begin
                cmd_wptr <= cmd_wptr + CMD_AW'(1);
            end
            if (cmd_pop) begin
                cmd_rptr <= cmd_rptr + CMD_AW'(1);
            end
            if (cmd_push && !cmd_pop) begin
                cmd_count <= cmd_count + CMD_CW'(1);
            end else if (!cmd_push && cmd_pop) begin
                cmd_count <= cmd_count - CMD_CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_wptr  <= '0;
            rsp_rptr  <= '0;
            rsp_count <= '0;
        end else begin
            if (rsp_push) begin
                rsp_wptr <= rsp_wptr + RSP_AW'(1);
            end
            if (rsp_pop) begin
                rsp_rptr <= rsp_rptr + RSP_AW'(1);
            end
            if (rsp_push && !rsp_pop) begin
                rsp_count <= rsp_count + RSP_CW'(1);
            end else if (!rsp_push && rsp_pop) begin
                rsp_count <= rsp_count - RSP_CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_accel_port.sv
module tb_accel_port;

  localparam int ID = 3;
  localparam int W  = 16;

  logic         clk;
  logic         rst;
  logic         loopback;
  logic [3:0]   accel_id;
  logic         accel_can_read;
  logic         accel_can_write;
  logic         accel_read_enable;
  logic [W-1:0] accel_read_data;
  logic         accel_write_enable;
  logic [W-1:0] accel_write_data;
  logic         cmd_valid;
  logic [W-1:0] cmd_data;
  logic         cmd_ready;
  logic         rsp_valid;
  logic [W-1:0] rsp_data;
  logic         rsp_ready;

  int checks;
  int failures;

  logic [W-1:0] exp_q[$];

  accel_port #(
    .ID(ID), .REG_WIDTH(W), .CMD_DEPTH(4), .RSP_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
`ifdef ACCEL_PORT_LOOPBACK_EN
    .loopback(loopback),
`endif
    .accel_id(accel_id),
    .accel_can_read(accel_can_read),
    .accel_can_write(accel_can_write),
    .accel_read_enable(accel_read_enable),
    .accel_read_data(accel_read_data),
    .accel_write_enable(accel_write_enable),
    .accel_write_data(accel_write_data),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_ready(cmd_ready),
    .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
    .rsp_ready(rsp_ready)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   id;
    logic         we;
    logic [W-1:0] wd;
    logic         re;
    logic         crdy;
    logic         rv;
    logic [W-1:0] rd;
    logic         e_cw;
    logic         e_cr;
    logic [W-1:0] e_rdata;
    logic         e_cv;
    logic [W-1:0] e_cd;
    logic         e_rr;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic [3:0] id, input logic we, input logic [W-1:0] wd,
                         input logic re, input logic crdy, input logic rv,
                         input logic [W-1:0] rd, input logic e_cw, input logic e_cr,
                         input logic [W-1:0] e_rdata, input logic e_cv,
                         input logic [W-1:0] e_cd, input logic e_rr);
    vec_t v;
    v.id = id; v.we = we; v.wd = wd; v.re = re; v.crdy = crdy; v.rv = rv; v.rd = rd;
    v.e_cw = e_cw; v.e_cr = e_cr; v.e_rdata = e_rdata; v.e_cv = e_cv; v.e_cd = e_cd;
    v.e_rr = e_rr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    accel_id = 4'(ID);
    accel_write_enable = 1'b0;
    accel_write_data = '0;
    accel_read_enable = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_data = '0;
    loopback = 1'b0;
  endtask

  // Advance to just after the next active edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic cpu_push(input logic [W-1:0] d);
    accel_write_enable = 1'b1;
    accel_write_data = d;
    next_cycle();
    accel_write_enable = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    do_reset();

    // ---- table-driven vectors: outputs checked in the cycle inputs apply ----
    //        id   we  wd       re crdy rv rd       cw cr rdata    cv cd       rr
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1);
    add_vec(4'd3, 1, 16'h1111, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1);
    add_vec(4'd3, 1, 16'h2222, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1111, 1);
    add_vec(4'd3, 1, 16'h3333, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1111, 1);
    add_vec(4'd3, 1, 16'h4444, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h1111, 1);
    add_vec(4'd3, 1, 16'h5555, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1111, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h1111, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h2222, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h3333, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 1, 0, 16'h0000, 1, 0, 16'h0000, 1, 16'h4444, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1);
    // core responses A5A5, 5A5A, then CPU reads both
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'hA5A5, 1, 0, 16'h0000, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h5A5A, 1, 1, 16'hA5A5, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'hA5A5, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h5A5A, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1);
    // deselected port ignores both enables
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h0BB0, 1, 0, 16'h0000, 0, 16'h0000, 1);
    add_vec(4'd4, 1, 16'h7777, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0BB0, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0BB0, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1);
    // response FIFO full: pushes refused, even alongside a CPU pop
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 16'h0000, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h0002, 1, 1, 16'h0001, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h0003, 1, 1, 16'h0001, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h0004, 1, 1, 16'h0001, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 1, 16'h0005, 1, 1, 16'h0001, 0, 16'h0000, 0);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 1, 16'h0006, 1, 1, 16'h0001, 0, 16'h0000, 0);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0002, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0003, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 1, 0, 0, 16'h0000, 1, 1, 16'h0004, 0, 16'h0000, 1);
    add_vec(4'd3, 0, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1);

    for (int i = 0; i < vq.size(); i++) begin
      accel_id = vq[i].id;
      accel_write_enable = vq[i].we;
      accel_write_data = vq[i].wd;
      accel_read_enable = vq[i].re;
      cmd_ready = vq[i].crdy;
      rsp_valid = vq[i].rv;
      rsp_data = vq[i].rd;
      #1;
      chk($sformatf("v%0d.can_write", i), W'(accel_can_write), W'(vq[i].e_cw));
      chk($sformatf("v%0d.can_read", i), W'(accel_can_read), W'(vq[i].e_cr));
      chk($sformatf("v%0d.read_data", i), accel_read_data, vq[i].e_rdata);
      chk($sformatf("v%0d.cmd_valid", i), W'(cmd_valid), W'(vq[i].e_cv));
      chk($sformatf("v%0d.cmd_data", i), cmd_data, vq[i].e_cd);
      chk($sformatf("v%0d.rsp_ready", i), W'(rsp_ready), W'(vq[i].e_rr));
      next_cycle();
    end
    idle_inputs();

    // ---- full command FIFO: push refused while core pops ----
    cpu_push(16'h00A0);
    cpu_push(16'h00A1);
    cpu_push(16'h00A2);
    cpu_push(16'h00A3);
    accel_write_enable = 1'b1;
    accel_write_data = 16'h9999;
    cmd_ready = 1'b1;
    #1;
    chk("full.can_write", W'(accel_can_write), W'(1'b0));
    chk("full.head", cmd_data, 16'h00A0);
    next_cycle();
    accel_write_enable = 1'b0;
    cmd_ready = 1'b0;
    #1;
    chk("full.can_write_after_pop", W'(accel_can_write), W'(1'b1));
    chk("full.head_after_pop", cmd_data, 16'h00A1);
    // drain: 9999 must never appear
    for (int k = 1; k < 4; k++) begin
      cmd_ready = 1'b1;
      #1;
      chk($sformatf("full.drain%0d", k), cmd_data, W'(16'h00A0 + k));
      next_cycle();
    end
    cmd_ready = 1'b0;
    #1;
    chk("full.empty_after_drain", W'(cmd_valid), W'(1'b0));

    // ---- pointer wrap: ten push/pop rounds through a scoreboard ----
    exp_q.delete();
    begin
      int got;
      got = 0;
      for (int c = 0; c < 14; c++) begin
        accel_write_enable = (c < 10);
        accel_write_data = W'(c);
        cmd_ready = 1'b1;
        #1;
        if (cmd_valid) begin
          if (exp_q.size() == 0) begin
            chk("wrap.unexpected_word", cmd_data, 16'hFFFF);
          end else begin
            chk($sformatf("wrap.word%0d", got), cmd_data, exp_q.pop_front());
            got++;
          end
        end
        if (accel_write_enable && accel_can_write) exp_q.push_back(accel_write_data);
        next_cycle();
      end
      idle_inputs();
      chk("wrap.count_received", W'(got), W'(10));
    end

    // ---- reset mid-operation discards everything, including same-cycle push ----
    cpu_push(16'h0C01);
    rsp_valid = 1'b1;
    rsp_data = 16'h0D01;
    next_cycle();
    rst = 1'b1;
    rsp_valid = 1'b1;
    rsp_data = 16'h0D02;
    accel_write_enable = 1'b1;
    accel_write_data = 16'h0C02;
    next_cycle();
    rst = 1'b0;
    idle_inputs();
    #1;
    chk("rst.cmd_valid", W'(cmd_valid), W'(1'b0));
    chk("rst.cmd_data", cmd_data, 16'h0000);
    chk("rst.can_read", W'(accel_can_read), W'(1'b0));
    chk("rst.read_data", accel_read_data, 16'h0000);
    chk("rst.can_write", W'(accel_can_write), W'(1'b1));
    chk("rst.rsp_ready", W'(rsp_ready), W'(1'b1));

`ifdef ACCEL_PORT_LOOPBACK_EN
    // ---- loopback: command returns as a response within 3 cycles ----
    begin
      bit seen;
      seen = 1'b0;
      loopback = 1'b1;
      accel_write_enable = 1'b1;
      accel_write_data = 16'h0BEE;
      #1;
      chk("lb.cmd_valid_push", W'(cmd_valid), W'(1'b0));
      next_cycle();
      accel_write_enable = 1'b0;
      for (int c = 0; c < 3 && !seen; c++) begin
        #1;
        chk($sformatf("lb.cmd_valid%0d", c), W'(cmd_valid), W'(1'b0));
        chk($sformatf("lb.rsp_ready%0d", c), W'(rsp_ready), W'(1'b0));
        if (accel_can_read) begin
          seen = 1'b1;
          chk("lb.read_data", accel_read_data, 16'h0BEE);
          accel_read_enable = 1'b1;
        end
        next_cycle();
      end
      accel_read_enable = 1'b0;
      chk("lb.seen_within_3", W'(seen), W'(1'b1));
      #1;
      chk("lb.can_read_after", W'(accel_can_read), W'(1'b0));
      loopback = 1'b0;
    end
`endif

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "time limit");
  end

endmodule
